// File: rtl/brick_field.sv
// Brick-field store for a breakout game: per-cell hardness, hit handling, pixel query.
// Optional BRICK_MULTIHIT_EN: upper half of the rows start with hardness 2.
module brick_field #(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 10,
  parameter int unsigned BRICK_W  = 64,
  parameter int unsigned BRICK_H  = 20,
  parameter int unsigned ORIGIN_X = 0,
  parameter int unsigned ORIGIN_Y = 40
) (
  input  logic                               Clk,
  input  logic                               Reset_n,
  input  logic                               load_req,
  output logic                               busy,
  input  logic                               hit_req,
  input  logic [2:0]                         hit_row,
  input  logic [3:0]                         hit_col,
  output logic                               hit_ack,
  output logic                               hit_broke,
  input  logic [9:0]                         DrawX,
  input  logic [9:0]                         DrawY,
  output logic                               brick_on,
  output logic [1:0]                         brick_level,
  output logic [$clog2(ROWS*COLS+1)-1:0]     remaining,
  output logic                               all_clear
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned RW = $clog2(N + 1);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {INIT, READY} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic            ack_q, ack_d;
  logic            broke_q, broke_d;
  logic            on_q, on_d;
  logic [1:0]      level_q, level_d;
  logic [1:0]      cell_q [N];

  logic            last_cell;
  logic [1:0]      init_val;
  logic            hit_in_range;
  logic [IW-1:0]   hit_idx;
  logic [1:0]      hit_cell;
  logic            hit_ok;
  logic            hit_last;
  logic            wr_en;
  logic [IW-1:0]   wr_idx;
  logic [1:0]      wr_val;
  int unsigned     px, py, q_col, q_row;
  logic            q_inside;
  logic [IW-1:0]   q_idx;
  logic [1:0]      q_cell;

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= INIT;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:    if (!load_req && last_cell) state_d = READY;
      READY:   if (load_req)               state_d = INIT;
      default: state_d = INIT;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == INIT);
  end

  assign last_cell = (32'(idx_q) == N - 1);

  always_comb begin
`ifdef BRICK_MULTIHIT_EN
    init_val = (32'(idx_q) < (ROWS / 2) * COLS) ? 2'd2 : 2'd1;
`else
    init_val = 2'd1;
`endif
  end

  // Hit decode; the index is forced to 0 when out of range so the read stays in bounds.
  always_comb begin
    hit_in_range = (32'(hit_row) < ROWS) && (32'(hit_col) < COLS);
    hit_idx      = hit_in_range ? IW'(32'(hit_row) * COLS + 32'(hit_col)) : '0;
    hit_cell     = cell_q[hit_idx];
    hit_ok       = hit_req && !load_req && (state_q == READY) && hit_in_range &&
                   (hit_cell != 2'd0);
    hit_last     = hit_ok && (hit_cell == 2'd1);
  end

  // Single cell write port shared by INIT fill and hit decrement (mutually exclusive by state).
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    wr_val = '0;
    if ((state_q == INIT) && !load_req) begin
      wr_en  = 1'b1;
      wr_idx = idx_q;
      wr_val = init_val;
    end else if (hit_ok) begin
      wr_en  = 1'b1;
      wr_idx = hit_idx;
      wr_val = hit_cell - 2'd1;
    end
  end

  always_comb begin
    idx_d = idx_q;
    rem_d = rem_q;
    if (load_req) begin
      idx_d = '0;
      rem_d = '0;
    end else if (state_q == INIT) begin
      idx_d = last_cell ? '0 : idx_q + IW'(1);
      rem_d = rem_q + RW'(1);
    end else if (hit_last) begin
      rem_d = rem_q - RW'(1);
    end
    ack_d   = hit_req;
    broke_d = hit_last;
  end

  // Pixel query: subtraction may wrap below the origin, masked by the range compares.
  always_comb begin
    px       = 32'(DrawX);
    py       = 32'(DrawY);
    q_col    = (px - ORIGIN_X) / BRICK_W;
    q_row    = (py - ORIGIN_Y) / BRICK_H;
    q_inside = (px >= ORIGIN_X) && (py >= ORIGIN_Y) && (q_col < COLS) && (q_row < ROWS);
    q_idx    = q_inside ? IW'(q_row * COLS + q_col) : '0;
    q_cell   = cell_q[q_idx];
    on_d     = !busy && q_inside && (q_cell != 2'd0);
    level_d  = on_d ? q_cell : 2'd0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      idx_q   <= '0;
      rem_q   <= '0;
      ack_q   <= 1'b0;
      broke_q <= 1'b0;
      on_q    <= 1'b0;
      level_q <= '0;
    end else begin
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      ack_q   <= ack_d;
      broke_q <= broke_d;
      on_q    <= on_d;
      level_q <= level_d;
    end
  end

  // Cell storage needs no reset: INIT rewrites every cell before it is ever read.
  always_ff @(posedge Clk) begin
    if (wr_en) cell_q[wr_idx] <= wr_val;
  end

  assign hit_ack     = ack_q;
  assign hit_broke   = broke_q;
  assign brick_on    = on_q;
  assign brick_level = level_q;
  assign remaining   = rem_q;
  assign all_clear   = (rem_q == '0) && !busy;

endmodule

// File: tb/tb_brick_field.sv
// Scoreboard bench for brick_field: hits push expected hit_broke, a monitor checks on hit_ack.
module tb_brick_field;
  localparam int ROWS = 4;
  localparam int COLS = 10;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       load_req = 1'b0;
  logic       hit_req = 1'b0;
  logic [2:0] hit_row = '0;
  logic [3:0] hit_col = '0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic       busy, hit_ack, hit_broke, brick_on, all_clear;
  logic [1:0] brick_level;
  logic [5:0] remaining;

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_q[$];
  int hard[ROWS][COLS];
  bit ready = 0;

  brick_field #(.ROWS(ROWS), .COLS(COLS), .BRICK_W(64), .BRICK_H(20),
                .ORIGIN_X(0), .ORIGIN_Y(40)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .load_req(load_req), .busy(busy),
    .hit_req(hit_req), .hit_row(hit_row), .hit_col(hit_col),
    .hit_ack(hit_ack), .hit_broke(hit_broke), .DrawX(DrawX), .DrawY(DrawY),
    .brick_on(brick_on), .brick_level(brick_level), .remaining(remaining),
    .all_clear(all_clear)
  );

  always #5 Clk = ~Clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int init_hard(int r);
`ifdef BRICK_MULTIHIT_EN
    return (r < ROWS / 2) ? 2 : 1;
`else
    return 1;
`endif
  endfunction

  task automatic model_load();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        hard[r][c] = init_hard(r);
    ready = 0;
  endtask

  function automatic int live_count();
    int n = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (hard[r][c] != 0) n++;
    return n;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Drive one hit for a cycle; the expected hit_broke comes from the hardness model.
  task automatic hit(int r, int c, bit with_load);
    int rr = r;
    int cc = c;
    hit_req = 1'b1;
    hit_row = rr[2:0];
    hit_col = cc[3:0];
    load_req = with_load;
    if (!with_load && ready && r < ROWS && c < COLS && hard[r][c] != 0) begin
      hard[r][c]--;
      exp_q.push_back(hard[r][c] == 0);
    end else begin
      exp_q.push_back(1'b0);
    end
    if (with_load) model_load();
    step();
    hit_req = 1'b0;
    load_req = 1'b0;
  endtask

  task automatic load();
    load_req = 1'b1;
    model_load();
    step();
    load_req = 1'b0;
  endtask

  task automatic wait_ready(string name, int exp_cycles);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    check(name, n, exp_cycles);
    ready = 1;
  endtask

  task automatic query(string name, int x, int y, int exp_on, int exp_lvl);
    DrawX = x[9:0];
    DrawY = y[9:0];
    step();
    check({name, "_on"}, brick_on, exp_on);
    check({name, "_lvl"}, brick_level, exp_lvl);
  endtask

  always @(posedge Clk) begin
    #1;
    if (hit_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ack: got hit_ack 1 expected no ack");
      end else begin
        bit e;
        e = exp_q.pop_front();
        check("hit_broke", hit_broke, e);
      end
    end
  end

  initial begin
    model_load();
    step();
    step();
    check("rst_busy", busy, 1);
    check("rst_remaining", remaining, 0);
    check("rst_all_clear", all_clear, 0);
    check("rst_hit_ack", hit_ack, 0);
    check("rst_brick_on", brick_on, 0);
    check("rst_level", brick_level, 0);

    Reset_n = 1'b1;
    wait_ready("init_cycles", 40);
    check("init_remaining", remaining, 40);
    check("init_all_clear", all_clear, 0);

    hit(1, 3, 0);
    check("hit13_remaining", remaining, live_count());
    hit(1, 3, 0);
    check("rehit13_remaining", remaining, live_count());

    query("q_64_40", 64, 40, 1, hard[0][1]);
    query("q_y39", 64, 39, 0, 0);
    query("q_x640", 640, 60, 0, 0);
    query("q_13", 197, 65, hard[1][3] != 0, hard[1][3]);

    hit(2, 12, 0);
    check("col12_remaining", remaining, live_count());
    hit(5, 0, 0);
    check("row5_remaining", remaining, live_count());

    hit(0, 0, 0);
    hit(0, 1, 0);
    hit(0, 0, 0);
    check("b2b_remaining", remaining, live_count());

    for (int pass = 0; pass < 2; pass++)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          hit(r, c, 0);
    step();
    check("clear_remaining", remaining, 0);
    check("clear_all_clear", all_clear, 1);
    query("q_cleared", 64, 40, 0, 0);

    hit(2, 2, 1);
    check("load_busy", busy, 1);
    check("load_all_clear", all_clear, 0);
    check("load_remaining0", remaining, 0);
    wait_ready("reload_cycles", 40);
    check("reload_remaining", remaining, 40);

    load();
    hit(0, 0, 0);
    wait_ready("reload2_cycles", 39);
    check("init_hit_remaining", remaining, 40);

    hit(0, 0, 0);
    query("q_00_after1", 5, 45, hard[0][0] != 0, hard[0][0]);
    hit(0, 0, 0);
    check("hit00x2_remaining", remaining, live_count());

    hit_req = 1'b1;
    hit_row = 3'd3;
    hit_col = 4'd4;
    #3;
    Reset_n = 1'b0;
    model_load();
    step();
    hit_req = 1'b0;
    check("midrst_hit_ack", hit_ack, 0);
    check("midrst_busy", busy, 1);
    check("midrst_remaining", remaining, 0);
    check("midrst_all_clear", all_clear, 0);
    step();
    Reset_n = 1'b1;
    wait_ready("rerst_cycles", 40);
    check("rerst_remaining", remaining, 40);
    step();
    step();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end
endmodule
